// File: rtl/rx_byte_fifo.sv
// Byte FIFO behind a serial receiver: one push per rising edge of rx_done, 1-cycle registered pop.
// Define RX_FIFO_OVERRUN_EN to enable the sticky overrun flag for dropped bytes.
module rx_byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       rx_data,
    input  logic                   rx_done,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   ovr_clr,
    output logic                   overrun
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("rx_byte_fifo: DEPTH must be a power of two in 2..256");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, full_q;
    logic             done_q;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             push, pop_ok, push_ok;

    assign push    = rx_done & ~done_q;
    assign pop_ok  = rd_en & ~empty_q;
    // A full FIFO still takes the byte if a pop frees the slot in the same cycle.
    assign push_ok = push & (~full_q | pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // done_q=1 keeps an rx_done held through reset from pushing afterwards.
            done_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            done_q     <= rx_done;
            rd_valid_q <= pop_ok;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

`ifdef RX_FIFO_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else if (push && !push_ok) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = ovr_clr;
    assign overrun        = 1'b0;
`endif

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;

endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data byte width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries; it SHALL be a power of two, 2..256.
REQ-003 Port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1, meaning reset; it is synchronous and active-low.
REQ-005 Port rx_data, input, WIDTH, meaning the received byte from the receiver stage.
REQ-006 Port rx_done, input, 1, meaning the receiver's byte-complete flag (level; may stay high for many cycles).
REQ-007 Port rd_en, input, 1, meaning the consumer's pop request.
REQ-008 Port rd_data, output, WIDTH, meaning the popped byte.
REQ-009 Port rd_valid, output, 1, meaning rd_data was updated this cycle.
REQ-010 Port empty, output, 1, meaning count==0.
REQ-011 Port full, output, 1, meaning count==DEPTH.
REQ-012 Port count, output, log2(DEPTH)+1, meaning the number of stored bytes.
REQ-013 Port ovr_clr, input, 1, meaning clear the overrun flag.
REQ-014 Port overrun, output, 1, meaning a byte was dropped.

Function
REQ-015 The block SHALL register rx_done into done_q and SHALL generate push = rx_done & ~done_q, one pulse per rising edge of rx_done.
REQ-016 On push, the block SHALL capture rx_data as sampled in the same cycle that push is high.
REQ-017 Write and read pointers SHALL be log2(DEPTH) bits wide and SHALL wrap DEPTH-1 -> 0 with no gap.
REQ-018 A push SHALL be accepted when ~full, or when full and a pop is accepted in the same cycle.
REQ-019 A pop SHALL be accepted when rd_en & ~empty; rd_en while empty SHALL be ignored, with no pointer change and rd_valid=0.
REQ-020 On an accepted pop, rd_data SHALL present the oldest byte and rd_valid SHALL be 1 on the next cycle (1-cycle latency); otherwise rd_valid=0 and rd_data SHALL hold its value.
REQ-021 When push and pop are accepted in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 When empty, a simultaneous push and rd_en SHALL accept only the push; the byte is readable from the next cycle.
REQ-023 count, empty and full SHALL be registered and SHALL reflect the state after the current edge's operations.
REQ-024 The block SHALL preserve order: bytes SHALL pop in push order, and none SHALL be duplicated.

Reset
REQ-025 While rst==0 at a clk edge, the block SHALL clear both pointers, count=0, empty=1, full=0, rd_valid=0, rd_data=0, overrun=0 and done_q=1.
REQ-026 Because done_q resets to 1, an rx_done held high through reset SHALL NOT cause a push after release.
REQ-027 Reset mid-operation SHALL discard all stored bytes; storage contents need not be cleared.

Configuration
REQ-028 With macro RX_FIFO_OVERRUN_EN defined, a push rejected by REQ-018 SHALL set overrun=1.
REQ-029 With RX_FIFO_OVERRUN_EN defined, overrun SHALL be sticky until ovr_clr=1 clears it on the next edge.
REQ-030 With RX_FIFO_OVERRUN_EN defined, if ovr_clr and a rejected push occur in the same cycle, the set SHALL win and overrun=1.
REQ-031 Without RX_FIFO_OVERRUN_EN, overrun SHALL be constant 0, ovr_clr SHALL be ignored, and rejected pushes SHALL still be dropped silently.

Verification
REQ-032 The bench SHALL cover: reset, then rx_done high for 5 cycles with rx_data=0xA5 -> exactly one push, count=1, empty=0.
REQ-033 The bench SHALL cover: push 0x01..0x10 (16 bytes), then pop 16 times -> full=1 after the 16th push, rd_data=0x01..0x10 in order, each with rd_valid one cycle after rd_en, empty=1 at the end.
REQ-034 The bench SHALL cover: FIFO full, push 0x77 -> byte dropped, count stays 16, overrun=1 (macro on) or overrun=0 (macro off); ovr_clr pulse -> overrun=0.
REQ-035 The bench SHALL cover: FIFO full, push 0x55 with rd_en in the same cycle -> count stays 16, overrun stays 0, and 0x55 is the last byte popped.
REQ-036 The bench SHALL cover: empty FIFO, push 0x3C with rd_en in the same cycle -> rd_valid=0 next cycle, count=1; rd_en on the following cycle -> rd_data=0x3C.
REQ-037 The bench SHALL cover: 20 push/pop cycles that cross pointer wrap, with rst=0 asserted at count=7 -> count=0, empty=1, and the first pop after refill returns the new byte.
